// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron datapath: default Q-format, channel
// count matching the downstream summation stage, FSM encoding and the
// debug view of the weighted input stage.
package neuron_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 16;
    localparam int N_CH      = 4;
    localparam int CH_W      = $clog2(N_CH);

    // Saturation limits of the default Q16.16 format.
    localparam logic [DEF_WIDTH-1:0] SAT_POS = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic [DEF_WIDTH-1:0] SAT_NEG = {1'b1, {(DEF_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef struct packed {
        state_t          state;
        logic [CH_W-1:0] index;
        logic            mul_ready;
    } dbg_t;

endpackage

// File: rtl/weighted_input_stage_if.sv
// Operand/result bundle of the weighted input stage.
// Handshake: start is taken only while the stage is idle (busy and done both
// low); a start seen while busy or during the done cycle is dropped, not
// queued. done is a single-cycle pulse; p0..p3 are valid from that cycle and
// hold until the next done pulse or reset.
interface weighted_input_stage_if #(
    parameter int WIDTH = neuron_pkg::DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] x0, x1, x2, x3;
    logic [WIDTH-1:0] w0, w1, w2, w3;
    logic [WIDTH-1:0] p0, p1, p2, p3;
    logic             busy;
    logic             done;

    modport master (
        output start, x0, x1, x2, x3, w0, w1, w2, w3,
        input  p0, p1, p2, p3, busy, done
    );

    modport slave (
        input  start, x0, x1, x2, x3, w0, w1, w2, w3,
        output p0, p1, p2, p3, busy, done
    );
endinterface

// File: rtl/fixed_mul_iter.sv
// Signed fixed-point iterative multiplier: one shift-add step per cycle on
// sign/magnitude operands, followed by a combinational rescale and saturate.
// go loads a new operand pair; result is final WIDTH cycles after go.
module fixed_mul_iter
    import neuron_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             ready
);

    localparam logic [WIDTH-1:0]   ONE_W     = WIDTH'(1);
    localparam logic [WIDTH-1:0]   MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   MAX_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    // Largest magnitude that fits a positive result; anything above it
    // saturates, and for negative results it is exactly the ">= 2^(W-1)" test.
    localparam logic [2*WIDTH-1:0] MAG_LIMIT = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               sign;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] mag;
    logic [WIDTH-1:0]   mag_lo;

    // Unsigned magnitudes; the most negative value maps to 2^(WIDTH-1) exactly.
    always_comb begin
        a_mag = a[WIDTH-1] ? (~a + ONE_W) : a;
        b_mag = b[WIDTH-1] ? (~b + ONE_W) : b;
    end

    // Shift-add core, LSB of the multiplier first; idles once no bits remain.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            sign   <= 1'b0;
        end else if (go) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            sign   <= a[WIDTH-1] ^ b[WIDTH-1];
        end else if (mplier != '0) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Rescale by truncating the magnitude, then saturate and reapply the sign.
    always_comb begin
        mag    = acc >> FRAC;
        mag_lo = mag[WIDTH-1:0];
        if (mag > MAG_LIMIT) begin
            result = sign ? MAX_NEG : MAX_POS;
        end else if (sign) begin
            result = ~mag_lo + ONE_W;
        end else begin
            result = mag_lo;
        end
    end

    assign ready = (mplier == '0);

endmodule

// File: rtl/weighted_input_stage.sv
// Forms p_i = x_i * w_i for four channels with one shared iterative
// multiplier and hands all four products to the summation stage together.
module weighted_input_stage
    import neuron_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic                    clk,
    input  logic                    reset,
    weighted_input_stage_if.slave   bus,
    output dbg_t                    dbg
);

    localparam int                ITER_W = $clog2(WIDTH);
    localparam logic [ITER_W-1:0] LAST_IT = ITER_W'(WIDTH - 1);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(N_CH - 1);

    state_t            state, next_state;
    logic [CH_W-1:0]   index, index_nxt;
    logic [ITER_W-1:0] iter;
    logic [WIDTH-1:0]  x_q [N_CH];
    logic [WIDTH-1:0]  w_q [N_CH];
    logic [WIDTH-1:0]  r_q [N_CH];
    logic [WIDTH-1:0]  p_q [N_CH];
    logic              mul_go;
    logic [WIDTH-1:0]  mul_a, mul_b, mul_result;
    logic              mul_ready;

    assign index_nxt = index + CH_W'(1);

    fixed_mul_iter #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
        .clk    (clk),
        .reset  (reset),
        .go     (mul_go),
        .a      (mul_a),
        .b      (mul_b),
        .result (mul_result),
        .ready  (mul_ready)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and multiplier launch; channel 0 takes the live inputs,
    // later channels take the operands latched at acceptance.
    always_comb begin
        next_state = state;
        mul_go     = 1'b0;
        mul_a      = bus.x0;
        mul_b      = bus.w0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    mul_go     = 1'b1;
                    next_state = S_MUL;
                end
            end
            S_MUL: begin
                if (iter == LAST_IT) begin
                    next_state = S_FIX;
                end
            end
            S_FIX: begin
                if (index == LAST_CH) begin
                    next_state = S_DONE;
                end else begin
                    mul_go     = 1'b1;
                    mul_a      = x_q[index_nxt];
                    mul_b      = w_q[index_nxt];
                    next_state = S_MUL;
                end
            end
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Operand latch; only meaningful after acceptance, so no reset needed.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.start) begin
            x_q <= '{bus.x0, bus.x1, bus.x2, bus.x3};
            w_q <= '{bus.w0, bus.w1, bus.w2, bus.w3};
        end
    end

    // Channel sequencing and result capture; the output bank is loaded on the
    // edge into DONE so p0..p3 are valid in the done cycle itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            index <= '0;
            iter  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_q[i] <= '0;
                p_q[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        index <= '0;
                        iter  <= '0;
                    end
                end
                S_MUL: begin
                    iter <= (iter == LAST_IT) ? '0 : iter + ITER_W'(1);
                end
                S_FIX: begin
                    r_q[index] <= mul_result;
                    if (index == LAST_CH) begin
                        for (int i = 0; i < N_CH - 1; i++) begin
                            p_q[i] <= r_q[i];
                        end
                        p_q[N_CH-1] <= mul_result;
                    end else begin
                        index <= index_nxt;
                    end
                end
                S_DONE: index <= '0;
                default: index <= '0;
            endcase
        end
    end

    assign bus.p0   = p_q[0];
    assign bus.p1   = p_q[1];
    assign bus.p2   = p_q[2];
    assign bus.p3   = p_q[3];
    assign bus.busy = (state == S_MUL) || (state == S_FIX);
    assign bus.done = (state == S_DONE);

    assign dbg = '{state: state, index: index, mul_ready: mul_ready};

endmodule

// File: doc/weighted_input_stage.md
Name: weighted_input_stage

Overview:
- Upstream neighbour of the four-input summation stage (MultiSum) in the neuron datapath.
- Accepts four activations x0..x3 and four weights w0..w3 as signed two's-complement fixed point.
- Forms the four products p_i = x_i * w_i with one iterative shift-add multiplier, shared by all four channels in sequence.
- Presents p0..p3 with a one-cycle done pulse; p0..p3 drive MultiSum in0..in3 and done drives MultiSum start.

Parameters:
- WIDTH, 32, data width of activations, weights and products.
- FRAC, 16, fractional bits (default format Q16.16); 0 <= FRAC < WIDTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a computation; sampled only in IDLE.
- x0, x1, x2, x3  in  WIDTH  signed activations.
- w0, w1, w2, w3  in  WIDTH  signed weights.
- p0, p1, p2, p3  out  WIDTH  signed saturated products.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; p0..p3 valid from this cycle on.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values: p0..p3=0, busy=0, done=0, state=IDLE, channel index=0, iteration counter=0.
- States: IDLE, MUL, FIX, DONE.
- IDLE + start=1:
  - Latch all eight operands.
  - Store |x| and |w| as WIDTH-bit unsigned magnitudes; |0x80000000| = 2^31 is exact.
  - Store sign = x[MSB] ^ w[MSB].
  - Clear the 2*WIDTH accumulator; index=0; go to MUL.
- MUL: one multiplier bit per cycle, LSB first: if the bit is set, add the shifted multiplicand into the accumulator. After WIDTH cycles go to FIX.
- FIX, one cycle:
  - mag = acc >> FRAC, which truncates the magnitude toward zero.
  - Positive result: if mag > 2^(WIDTH-1)-1, result = 0x7FFFFFFF; else result = mag.
  - Negative result: if mag >= 2^(WIDTH-1), result = 0x80000000; else result = -mag.
  - A zero magnitude gives 0, never negative zero.
  - Write the result to internal register r[index].
  - index<3: index++, load the next operand pair, clear the accumulator, go to MUL.
  - index==3: go to DONE.
- DONE, one cycle: p0..p3 <= r0..r3 together; done=1; busy=0; then go to IDLE.
- Latency: start sampled on edge 0; done high in cycle 4*(WIDTH+1)+1 = 133 for WIDTH=32. The count is fixed and independent of the data.
- Output stability: p0..p3 never change except in DONE or on reset, so they hold the previous results for the whole of the next computation.
- start while busy: ignored, not queued. Operand inputs may change freely after acceptance.
- start held high: a new computation is accepted in the cycle after DONE (back-to-back period 134 cycles).
- Reset mid-operation: abort; all outputs and state return to reset values on the next edge. No done pulse is produced.
- Reset and start in the same cycle: reset wins.

Decomposition:
- Shared package neuron_pkg:
  - WIDTH and FRAC defaults.
  - N_CH=4, matching MultiSum's input count.
  - State encoding localparams.
  - Q-format constants SAT_POS and SAT_NEG.
- Sub-module fixed_mul_iter: one signed WIDTH x WIDTH iterative multiplier.
  - Ports: clk, reset, go, a, b, result, ready.
  - Contains the magnitude, shift-add and FIX/saturate logic.
  - The top level sequences the four channels and holds r0..r3.

Test Plan:
- Reset, then x0=0x00020000 (2.0), w0=0x00018000 (1.5), all other channels 0; start pulse -> done exactly 133 cycles after the start edge; p0=0x00030000, p1..p3=0; busy high for cycles 1..132.
- Signs: x1=0xFFFF0000 (-1.0), w1=0x00008000 (0.5) -> p1=0xFFFF8000. x2=0xFFFE0000, w2=0xFFFF0000 -> p2=0x00020000. x3=0, w3=0x80000000 -> p3=0.
- Truncation: x0=0x00000001, w0=0x00008000 -> p0=0. x1=0xFFFFFFFF, w1=0x00018000 -> p1=0xFFFFFFFF.
- Saturation: x0=0x7FFFFFFF, w0=0x00020000 -> p0=0x7FFFFFFF. x1=0x80000000, w1=0x00020000 -> p1=0x80000000. x2=0x80000000, w2=0x00010000 -> p2=0x80000000.
- Protocol:
  - Second start at cycle 50 -> ignored; still exactly one done at 133.
  - start held high -> done pulses at 133 and 267.
  - p0..p3 hold the first results until the second done.
- Reset asserted at cycle 70 -> next edge: busy=0, p=0, state IDLE, no done; a fresh start then completes normally in 133 cycles.
